// File: rtl/hwpe_stream_protocol_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : hwpe_stream_protocol_checker                                      |
// | Brief  : Passive HWPE stream monitor flagging VCR/VDR/stall-timeout errors |
// |          and counting handshakes and stall cycles per channel.             |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module hwpe_stream_protocol_checker #(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned CNT_WIDTH     = 16,
  parameter int unsigned STALL_TIMEOUT = 1024,
  parameter int unsigned BYPASS_VCR    = 0,
  parameter int unsigned BYPASS_VDR    = 0,
  localparam int unsigned STRB_WIDTH   = DATA_WIDTH / 8,
  localparam int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             enable_i,
  input  logic                             clear_i,
  input  logic [NUM_CH-1:0]                valid_i,
  input  logic [NUM_CH-1:0]                ready_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0]     data_i,
  input  logic [NUM_CH*STRB_WIDTH-1:0]     strb_i,
  output logic [NUM_CH-1:0]                vcr_err_o,
  output logic [NUM_CH-1:0]                vdr_err_o,
  output logic [NUM_CH-1:0]                tmo_err_o,
  output logic                             err_o,
  output logic                             first_err_valid_o,
  output logic [CH_W-1:0]                  first_err_ch_o,
  output logic [1:0]                       first_err_code_o,
  output logic [NUM_CH*CNT_WIDTH-1:0]      hs_cnt_o,
  output logic [NUM_CH*CNT_WIDTH-1:0]      stall_cnt_o
);

  localparam int unsigned RUN_W = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
  localparam logic [RUN_W-1:0]     c_run_max  = RUN_W'(STALL_TIMEOUT);
  localparam logic [RUN_W-1:0]     c_run_last = RUN_W'((STALL_TIMEOUT > 0) ? STALL_TIMEOUT - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] c_cnt_max  = '1;

  logic                          r_hist_vld;
  logic [NUM_CH-1:0]             r_valid_q;
  logic [NUM_CH-1:0]             r_ready_q;
  logic [NUM_CH*DATA_WIDTH-1:0]  r_data_q;
  logic [NUM_CH*STRB_WIDTH-1:0]  r_strb_q;

  logic [NUM_CH-1:0]             w_vcr_det;
  logic [NUM_CH-1:0]             w_vdr_det;
  logic [NUM_CH-1:0]             w_tmo_det;

  logic                          w_any_det;
  logic [CH_W-1:0]               w_sel_ch;
  logic [1:0]                    w_sel_code;
  logic                          r_first_vld;
  logic [CH_W-1:0]               r_first_ch;
  logic [1:0]                    r_first_code;

  // History is never gated by enable so checks resume on clean context.
  always_ff @(posedge clk_i) begin
    r_valid_q <= valid_i;
    r_ready_q <= ready_i;
    r_data_q  <= data_i;
    r_strb_q  <= strb_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_hist_vld <= 1'b0;
    else       r_hist_vld <= 1'b1;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic                 w_pend;
    logic                 w_stall;
    logic                 w_hs;
    logic                 w_data_chg;
    logic [RUN_W-1:0]     r_run;
    logic [CNT_WIDTH-1:0] r_hs_cnt;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic                 r_vcr;
    logic                 r_vdr;
    logic                 r_tmo;

    assign w_pend     = r_hist_vld & r_valid_q[c] & ~r_ready_q[c];
    assign w_stall    = enable_i & valid_i[c] & ~ready_i[c];
    assign w_hs       = enable_i & valid_i[c] & ready_i[c];
    assign w_data_chg = (data_i[c*DATA_WIDTH +: DATA_WIDTH] != r_data_q[c*DATA_WIDTH +: DATA_WIDTH]) |
                        (strb_i[c*STRB_WIDTH +: STRB_WIDTH] != r_strb_q[c*STRB_WIDTH +: STRB_WIDTH]);

    assign w_vcr_det[c] = (BYPASS_VCR == 0) & enable_i & w_pend & w_data_chg;
    assign w_vdr_det[c] = (BYPASS_VDR == 0) & enable_i & w_pend & ~valid_i[c];
    // Fires only on the cycle the run reaches the limit, not while saturated.
    assign w_tmo_det[c] = (STALL_TIMEOUT != 0) & w_stall & (r_run == c_run_last);

    always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
        r_run <= '0;
      end else if (w_stall) begin
        if (r_run != c_run_max) r_run <= r_run + 1'b1;
      end else begin
        r_run <= '0;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
        r_hs_cnt    <= '0;
        r_stall_cnt <= '0;
      end else begin
        if (w_hs && (r_hs_cnt != c_cnt_max))       r_hs_cnt    <= r_hs_cnt + 1'b1;
        if (w_stall && (r_stall_cnt != c_cnt_max)) r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
        r_vcr <= 1'b0;
        r_vdr <= 1'b0;
        r_tmo <= 1'b0;
      end else begin
        r_vcr <= r_vcr | w_vcr_det[c];
        r_vdr <= r_vdr | w_vdr_det[c];
        r_tmo <= r_tmo | w_tmo_det[c];
      end
    end

    assign vcr_err_o[c] = r_vcr;
    assign vdr_err_o[c] = r_vdr;
    assign tmo_err_o[c] = r_tmo;
    assign hs_cnt_o[c*CNT_WIDTH +: CNT_WIDTH]    = r_hs_cnt;
    assign stall_cnt_o[c*CNT_WIDTH +: CNT_WIDTH] = r_stall_cnt;
  end

  // Descending scan so the lowest detecting channel is the last one written.
  always_comb begin
    w_any_det  = 1'b0;
    w_sel_ch   = '0;
    w_sel_code = 2'b00;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_vcr_det[i] || w_vdr_det[i] || w_tmo_det[i]) begin
        w_any_det = 1'b1;
        w_sel_ch  = CH_W'(i);
        if (w_vcr_det[i])      w_sel_code = 2'b01;
        else if (w_vdr_det[i]) w_sel_code = 2'b10;
        else                   w_sel_code = 2'b11;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_first_vld  <= 1'b0;
      r_first_ch   <= '0;
      r_first_code <= 2'b00;
    end else if (!r_first_vld && w_any_det) begin
      r_first_vld  <= 1'b1;
      r_first_ch   <= w_sel_ch;
      r_first_code <= w_sel_code;
    end
  end

  assign first_err_valid_o = r_first_vld;
  assign first_err_ch_o    = r_first_ch;
  assign first_err_code_o  = r_first_code;
  assign err_o             = |{vcr_err_o, vdr_err_o, tmo_err_o};

endmodule
`default_nettype wire

// File: tb/tb_hwpe_stream_protocol_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_hwpe_stream_protocol_checker                                   |
// | Brief  : Directed self-checking bench for hwpe_stream_protocol_checker.    |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_hwpe_stream_protocol_checker;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned DW     = 32;
  localparam int unsigned CW     = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 enable;
  logic                 clear;
  logic [NUM_CH-1:0]    valid;
  logic [NUM_CH-1:0]    ready;
  logic [NUM_CH*DW-1:0] data;
  logic [NUM_CH*4-1:0]  strb;
  logic [NUM_CH-1:0]    vcr_err, vdr_err, tmo_err;
  logic                 err, first_vld;
  logic [0:0]           first_ch;
  logic [1:0]           first_code;
  logic [NUM_CH*CW-1:0] hs_cnt, stall_cnt;

  int checks   = 0;
  int failures = 0;

  hwpe_stream_protocol_checker #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .CNT_WIDTH(CW),
    .STALL_TIMEOUT(4), .BYPASS_VCR(0), .BYPASS_VDR(0)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear),
    .valid_i(valid), .ready_i(ready), .data_i(data), .strb_i(strb),
    .vcr_err_o(vcr_err), .vdr_err_o(vdr_err), .tmo_err_o(tmo_err),
    .err_o(err), .first_err_valid_o(first_vld), .first_err_ch_o(first_ch),
    .first_err_code_o(first_code), .hs_cnt_o(hs_cnt), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic v, input logic r, input logic [DW-1:0] d);
    valid[c]          = v;
    ready[c]          = r;
    data[c*DW +: DW]  = d;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; clear = 1'b0;
    valid = '0; ready = '0; data = '0; strb = '1;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({vcr_err, vdr_err, tmo_err, err, first_vld, first_code} !== '0) begin
      failures++; $display("FAIL reset_flags: got %b required 0", {vcr_err, vdr_err, tmo_err, err, first_vld, first_code});
    end
    checks++;
    if ({hs_cnt, stall_cnt} !== '0) begin
      failures++; $display("FAIL reset_counters: got %h required 0", {hs_cnt, stall_cnt});
    end
  endtask

  task automatic test_vcr();
    set_ch(0, 1'b1, 1'b0, 32'hA5);
    tick(); tick(); tick();
    checks++;
    if (vcr_err !== 2'b00) begin
      failures++; $display("FAIL vcr_before_change: got %b required 00", vcr_err);
    end
    set_ch(0, 1'b1, 1'b0, 32'h5A);
    tick();
    checks++;
    if (vcr_err !== 2'b01) begin
      failures++; $display("FAIL vcr_flag: got %b required 01", vcr_err);
    end
    checks++;
    if ({first_vld, first_ch, first_code} !== 4'b1_0_01) begin
      failures++; $display("FAIL vcr_first: got %b required 1001", {first_vld, first_ch, first_code});
    end
    checks++;
    if ({vcr_err[1], vdr_err[1], tmo_err[1]} !== 3'b000) begin
      failures++; $display("FAIL vcr_ch1_clean: got %b required 000", {vcr_err[1], vdr_err[1], tmo_err[1]});
    end
    checks++;
    if (stall_cnt[3:0] !== 4'd4) begin
      failures++; $display("FAIL vcr_stall_cnt: got %0d required 4", stall_cnt[3:0]);
    end
    set_ch(0, 1'b1, 1'b1, 32'h5A); tick();
    set_ch(0, 1'b0, 1'b0, 32'h0);  tick();
    do_clear();
  endtask

  task automatic test_vdr();
    set_ch(1, 1'b1, 1'b0, 32'h1234); tick();
    set_ch(1, 1'b0, 1'b0, 32'h1234); tick();
    checks++;
    if (vdr_err !== 2'b10 || err !== 1'b1) begin
      failures++; $display("FAIL vdr_flag: got vdr=%b err=%b required vdr=10 err=1", vdr_err, err);
    end
    checks++;
    if (hs_cnt[7:4] !== 4'd0 || stall_cnt[7:4] !== 4'd1) begin
      failures++; $display("FAIL vdr_counts: got hs=%0d stall=%0d required hs=0 stall=1", hs_cnt[7:4], stall_cnt[7:4]);
    end
    checks++;
    if ({first_vld, first_ch, first_code} !== 4'b1_1_10) begin
      failures++; $display("FAIL vdr_first: got %b required 1110", {first_vld, first_ch, first_code});
    end
    do_clear();
  endtask

  task automatic test_simul_vcr_clear();
    set_ch(0, 1'b1, 1'b0, 32'h11); set_ch(1, 1'b1, 1'b0, 32'h22); tick();
    set_ch(0, 1'b1, 1'b0, 32'h33); set_ch(1, 1'b1, 1'b0, 32'h44); tick();
    checks++;
    if (vcr_err !== 2'b11 || tmo_err !== 2'b00) begin
      failures++; $display("FAIL simul_vcr: got vcr=%b tmo=%b required vcr=11 tmo=00", vcr_err, tmo_err);
    end
    checks++;
    if ({first_vld, first_ch, first_code} !== 4'b1_0_01) begin
      failures++; $display("FAIL simul_first: got %b required 1001", {first_vld, first_ch, first_code});
    end
    // Dropping valid during clear is a VDR detect that clear must override.
    valid = '0; ready = '0;
    do_clear();
    checks++;
    if ({vcr_err, vdr_err, tmo_err, err, first_vld} !== '0 || {hs_cnt, stall_cnt} !== '0) begin
      failures++; $display("FAIL clear_all: got flags=%b cnt=%h required 0", {vcr_err, vdr_err, tmo_err, err, first_vld}, {hs_cnt, stall_cnt});
    end
  endtask

  task automatic test_timeout();
    set_ch(0, 1'b1, 1'b0, 32'h77);
    tick(); tick(); tick();
    checks++;
    if (tmo_err !== 2'b00) begin
      failures++; $display("FAIL tmo_early: got %b required 00", tmo_err);
    end
    tick();
    checks++;
    if (tmo_err !== 2'b01 || {first_vld, first_ch, first_code} !== 4'b1_0_11) begin
      failures++; $display("FAIL tmo_flag: got tmo=%b first=%b required tmo=01 first=1011", tmo_err, {first_vld, first_ch, first_code});
    end
    set_ch(0, 1'b1, 1'b1, 32'h77); tick();
    set_ch(0, 1'b0, 1'b0, 32'h0);  tick();
    do_clear();
    set_ch(0, 1'b1, 1'b0, 32'h88);
    tick(); tick(); tick();
    set_ch(0, 1'b1, 1'b1, 32'h88);
    tick();
    checks++;
    if (tmo_err !== 2'b00 || hs_cnt[3:0] !== 4'd1 || stall_cnt[3:0] !== 4'd3) begin
      failures++; $display("FAIL tmo_avoided: got tmo=%b hs=%0d stall=%0d required tmo=00 hs=1 stall=3", tmo_err, hs_cnt[3:0], stall_cnt[3:0]);
    end
    set_ch(0, 1'b0, 1'b0, 32'h0); tick();
    do_clear();
  endtask

  task automatic test_back_to_back();
    set_ch(0, 1'b1, 1'b1, 32'hCAFE);
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (hs_cnt[3:0] !== 4'd15) begin
      failures++; $display("FAIL hs_reach_max: got %0d required 15", hs_cnt[3:0]);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (hs_cnt[3:0] !== 4'd15) begin
      failures++; $display("FAIL hs_saturate: got %0d required 15", hs_cnt[3:0]);
    end
    do_clear();
    checks++;
    if (hs_cnt[3:0] !== 4'd0) begin
      failures++; $display("FAIL clear_vs_hs: got %0d required 0", hs_cnt[3:0]);
    end
    tick();
    checks++;
    if (hs_cnt[3:0] !== 4'd1 || err !== 1'b0) begin
      failures++; $display("FAIL hs_after_clear: got hs=%0d err=%b required hs=1 err=0", hs_cnt[3:0], err);
    end
    set_ch(0, 1'b0, 1'b0, 32'h0); tick();
    do_clear();
  endtask

  task automatic test_reset_mid();
    set_ch(0, 1'b1, 1'b0, 32'h100); tick(); tick();
    rst = 1'b1;
    set_ch(0, 1'b1, 1'b0, 32'h200); tick();
    rst = 1'b0;
    set_ch(0, 1'b1, 1'b0, 32'h300); tick();
    checks++;
    if (vcr_err !== 2'b00 || err !== 1'b0 || first_vld !== 1'b0) begin
      failures++; $display("FAIL reset_release: got vcr=%b err=%b first=%b required 0", vcr_err, err, first_vld);
    end
    checks++;
    if (stall_cnt[3:0] !== 4'd1) begin
      failures++; $display("FAIL reset_release_stall: got %0d required 1", stall_cnt[3:0]);
    end
    tick();
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL reset_steady: got %b required 0", err);
    end
    set_ch(0, 1'b1, 1'b1, 32'h300); tick();
    set_ch(0, 1'b0, 1'b0, 32'h0);   tick();
    do_clear();
  endtask

  task automatic test_enable();
    enable = 1'b0;
    set_ch(1, 1'b1, 1'b0, 32'hAAAA); tick();
    set_ch(1, 1'b0, 1'b0, 32'hBBBB); tick();
    checks++;
    if (vcr_err !== 2'b00 || vdr_err !== 2'b00 || err !== 1'b0) begin
      failures++; $display("FAIL enable_off_flags: got vcr=%b vdr=%b err=%b required 0", vcr_err, vdr_err, err);
    end
    checks++;
    if (stall_cnt[7:4] !== 4'd0) begin
      failures++; $display("FAIL enable_off_count: got %0d required 0", stall_cnt[7:4]);
    end
    enable = 1'b1;
    tick();
    checks++;
    if (err !== 1'b0 || first_vld !== 1'b0) begin
      failures++; $display("FAIL enable_resume: got err=%b first=%b required 0", err, first_vld);
    end
  endtask

  initial begin
    test_reset();
    test_vcr();
    test_vdr();
    test_simul_vcr_clear();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_enable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
